// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter
//   Shares a single-port data memory between the CPU and an external host.
//   While idle the CPU owns the memory port combinationally. An accepted host
//   request freezes the CPU (cpu_stall) and runs a word-sized burst of
//   host_len+1 beats, writing beats from the host or returning read beats
//   one at a time with a valid/ready handshake. A one-cycle host_done pulse
//   ends every completed burst.
//
// Ports
//   clk, reset                 single clock, asynchronous active-high reset
//   cpu_mem_write/adr/wdata/funct3
//                              CPU data-memory request (passed through in IDLE)
//   host_valid/ready/write/adr/len/wdata
//                              host request and write-beat channel
//   host_rvalid/rready/rdata   host read-return channel
//   host_done                  one-cycle burst-complete pulse
//   cpu_stall                  CPU freeze while a host burst owns the memory
//   busy                       arbiter is serving the host
//   mem_write/adr/wdata/funct3 memory port; mem_rdata is combinational read data
module ext_mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_funct3,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_adr,
  input  logic [LEN_W-1:0]  host_len,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  input  logic              host_rready,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_done,
  output logic              cpu_stall,
  output logic              busy,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  typedef enum logic [2:0] {IDLE, WBURST, RADDR, RHOLD, DONE} state_t;

  state_t            state, nextState;
  logic [ADDR_W-1:0] baseAdr;
  logic [LEN_W-1:0]  lenReg;
  logic [LEN_W-1:0]  count;
  logic [ADDR_W-1:0] beatAdr;
  logic              lastBeat;

  // Byte address of beat cnt; the add is ADDR_W wide so bursts wrap silently.
  function automatic logic [ADDR_W-1:0] beatAddr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  cnt);
    return base + (ADDR_W'(cnt) << 2);
  endfunction

  assign beatAdr  = beatAddr(baseAdr, count);
  assign lastBeat = (count == lenReg);

  // Request acceptance: state register and beat counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case (state)
        IDLE:    if (host_valid)  count <= '0;
        WBURST:  if (host_valid)  count <= count + LEN_W'(1);
        RHOLD:   if (host_rready) count <= count + LEN_W'(1);
        default: ;
      endcase
    end
  end

  // Burst base and length are plain data: only meaningful once a request is
  // accepted, so they carry no reset. Direction is not stored; it is encoded
  // by which burst state the FSM enters.
  always_ff @(posedge clk) begin
    if (state == IDLE && host_valid) begin
      baseAdr <= host_adr;
      lenReg  <= host_len;
    end
  end

  // Read return: capture the combinational memory data on leaving RADDR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_rdata <= '0;
    end else if (state == RADDR) begin
      host_rdata <= mem_rdata;
    end
  end

  assign host_rvalid = (state == RHOLD);

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (host_valid) nextState = host_write ? WBURST : RADDR;
      WBURST:  if (host_valid && lastBeat) nextState = DONE;
      RADDR:   nextState = RHOLD;
      RHOLD:   if (host_rready) nextState = lastBeat ? DONE : RADDR;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Memory port mux and handshake outputs
  always_comb begin
    mem_write  = 1'b0;
    mem_adr    = beatAdr;
    mem_wdata  = host_wdata;
    mem_funct3 = FUNCT3_WORD;
    host_ready = 1'b0;
    cpu_stall  = 1'b1;
    busy       = 1'b1;
    host_done  = 1'b0;
    case (state)
      IDLE: begin
        // The CPU access in the acceptance cycle still reaches memory.
        mem_write  = cpu_mem_write;
        mem_adr    = cpu_adr;
        mem_wdata  = cpu_wdata;
        mem_funct3 = cpu_funct3;
        host_ready = 1'b1;
        cpu_stall  = 1'b0;
        busy       = 1'b0;
      end
      WBURST: begin
        host_ready = 1'b1;
        mem_write  = host_valid;
      end
      DONE:    host_done = 1'b1;
      default: ;
    endcase
  end

endmodule
